// File: rtl/interrupt_ctrl_if.sv
// CPU-side handshake bundle for interrupt_ctrl: the controller presents (int1, x),
// and the CPU answers with single-cycle ack and eoi pulses.
interface interrupt_ctrl_if #(
    parameter int N_SRC = 8
);
    localparam int ID_W = $clog2(N_SRC);

    logic            ack;
    logic            eoi;
    logic            int1;
    logic            busy;
    logic [ID_W-1:0] x;

    modport master (output ack, output eoi, input int1, input x, input busy);
    modport slave  (input ack, input eoi, output int1, output x, output busy);
endinterface

// File: rtl/interrupt_ctrl.sv
// Registered N_SRC-input interrupt controller: pending capture, mask, fixed priority
// (highest index wins), and an ack/eoi handshake. Edge-mode sources need INTERRUPT_EDGE_EN.
module interrupt_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   p,
    input  logic [N_SRC-1:0]   mask,
    input  logic [N_SRC-1:0]   edge_mode,
    output logic [N_SRC-1:0]   pend_o,
    output logic [1:0]         dbg_state,
    interrupt_ctrl_if.slave    cpu
);
    localparam int ID_W = $clog2(N_SRC);

    // Handshake: int1 high means x is offered; ack (a one-cycle pulse) is honoured
    // only in REQ, eoi (a one-cycle pulse) only in SERVICE, and ack takes precedence.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    logic [N_SRC-1:0]  pend;
    logic [N_SRC-1:0]  pend_nxt;
    logic [N_SRC-1:0]  req;
    logic [ID_W-1:0]   win;
    logic              ack_take;

    assign req       = pend & mask;
    assign ack_take  = (state == REQ) && cpu.ack;
    assign pend_o    = pend;
    assign dbg_state = state;

    always_comb begin
        win = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) win = ID_W'(i);
        end
    end

`ifdef INTERRUPT_EDGE_EN
    logic [N_SRC-1:0] p_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;

    assign rise = p & ~p_q;
    assign clr  = ack_take ? (N_SRC'(1) << cpu.x) : '0;
    // A rising edge in the same cycle as the ack clear keeps the bit set.
    assign pend_nxt = (edge_mode & (rise | (pend & ~clr))) | (~edge_mode & p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else     p_q <= p;
    end
`else
    logic unused_edge_mode;
    assign unused_edge_mode = ^edge_mode;
    assign pend_nxt = p;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cpu.int1 <= 1'b0;
            cpu.busy <= 1'b0;
            cpu.x    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        cpu.x    <= win;
                        cpu.int1 <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (cpu.ack) begin
                        cpu.int1 <= 1'b0;
                        cpu.busy <= 1'b1;
                        state    <= SERVICE;
                    end else if (!req[cpu.x]) begin
                        // Request withdrawn before the CPU took it.
                        cpu.int1 <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SERVICE: begin
                    if (cpu.eoi) begin
                        cpu.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    cpu.int1 <= 1'b0;
                    cpu.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: expected ids are queued when a request is issued
// and checked by a monitor whenever int1 rises; status outputs are checked inline.
module tb_interrupt_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] p = '0;
  logic [N-1:0] mask = '1;
  logic [N-1:0] edge_mode = '0;
  logic [N-1:0] pend_o;
  logic [1:0]   dbg_state;

  interrupt_ctrl_if #(.N_SRC(N)) cpu ();

  interrupt_ctrl #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .mask      (mask),
    .edge_mode (edge_mode),
    .pend_o    (pend_o),
    .dbg_state (dbg_state),
    .cpu       (cpu)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [2:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic int1_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cpu.int1 && !int1_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_int: got x=%0d expected no interrupt at %0t", cpu.x, $time);
      end else begin
        check("presented_id", 32'(cpu.x), 32'(exp_q.pop_front()));
      end
    end
    int1_prev = cpu.int1;
  end

  // drivers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    cpu.ack = 1'b1; tick(); cpu.ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    cpu.eoi = 1'b1; tick(); cpu.eoi = 1'b0;
  endtask

  initial begin
    cpu.ack = 1'b0;
    cpu.eoi = 1'b0;
    tick(3);
    check("reset_int1", 32'(cpu.int1), 0);
    check("reset_busy", 32'(cpu.busy), 0);
    check("reset_x",    32'(cpu.x), 0);
    check("reset_pend", 32'(pend_o), 0);
    rst = 1'b0;
    tick();

    // priority: highest index wins, lower one follows after eoi
    p = 8'b1000_0001; exp_q.push_back(3'd7);
    tick(2);
    check("prio_int1", 32'(cpu.int1), 1);
    check("prio_x",    32'(cpu.x), 7);
    pulse_ack();
    check("svc_busy", 32'(cpu.busy), 1);
    check("svc_int1", 32'(cpu.int1), 0);
    p = 8'h01;
    tick();
    exp_q.push_back(3'd0);
    pulse_eoi();
    check("eoi_busy", 32'(cpu.busy), 0);
    tick();
    check("rereq_int1", 32'(cpu.int1), 1);
    check("rereq_x",    32'(cpu.x), 0);
    p = 8'h00;
    pulse_ack();
    pulse_eoi();
    tick();
    check("idle_after_eoi", 32'(cpu.int1), 0);

    // masking and withdrawal by mask
    p = 8'h90; mask = 8'h10; exp_q.push_back(3'd4);
    tick(2);
    check("mask_x",    32'(cpu.x), 4);
    check("mask_int1", 32'(cpu.int1), 1);
    mask = 8'h00;
    tick();
    check("maskoff_int1", 32'(cpu.int1), 0);
    check("maskoff_pend", 32'(pend_o), 32'h90);
    check("maskoff_state", 32'(dbg_state), 0);
    p = 8'h00;
    tick();
    mask = 8'hFF;
    tick(2);
    check("quiet_int1", 32'(cpu.int1), 0);

    // handshake misuse
    pulse_ack();
    check("ack_idle_busy", 32'(cpu.busy), 0);
    check("ack_idle_int1", 32'(cpu.int1), 0);
    p = 8'h08; exp_q.push_back(3'd3);
    tick(2);
    check("misuse_x", 32'(cpu.x), 3);
    pulse_eoi();
    check("eoi_req_int1", 32'(cpu.int1), 1);
    check("eoi_req_busy", 32'(cpu.busy), 0);
    cpu.ack = 1'b1; cpu.eoi = 1'b1;
    tick();
    cpu.ack = 1'b0; cpu.eoi = 1'b0;
    check("ackeoi_busy", 32'(cpu.busy), 1);
    check("ackeoi_int1", 32'(cpu.int1), 0);
    p = 8'h00;
    pulse_eoi();
    tick();

    // x frozen in REQ despite higher arrival, then level withdrawal
    p = 8'h20; exp_q.push_back(3'd5);
    tick(2);
    p = 8'hA0;
    tick(2);
    check("frozen_x",    32'(cpu.x), 5);
    check("frozen_int1", 32'(cpu.int1), 1);
    p = 8'h00;
    tick(2);
    check("withdraw_int1", 32'(cpu.int1), 0);
    check("withdraw_pend", 32'(pend_o), 0);
    tick(2);

`ifdef INTERRUPT_EDGE_EN
    edge_mode = 8'h04;
    tick();
    p = 8'h04; tick(); p = 8'h00;
    exp_q.push_back(3'd2);
    tick();
    check("edge_x", 32'(cpu.x), 2);
    tick(2);
    check("edge_pend_held", 32'(pend_o[2]), 1);
    pulse_ack();
    check("edge_pend_clr", 32'(pend_o[2]), 0);
    p = 8'h04; tick(); p = 8'h00;
    tick();
    check("edge_pend_svc", 32'(pend_o), 32'h04);
    exp_q.push_back(3'd2);
    pulse_eoi();
    tick();
    check("edge_renew_int1", 32'(cpu.int1), 1);
    check("edge_renew_x",    32'(cpu.x), 2);
    cpu.ack = 1'b1; p = 8'h04;
    tick();
    cpu.ack = 1'b0; p = 8'h00;
    check("setclr_pend", 32'(pend_o[2]), 1);
    check("setclr_busy", 32'(cpu.busy), 1);
    exp_q.push_back(3'd2);
    pulse_eoi();
    tick();
    pulse_ack();
    pulse_eoi();
    check("edge_done_pend", 32'(pend_o), 0);
    edge_mode = 8'h00;
    tick(2);
`endif

    // async reset mid-SERVICE
    p = 8'h40; exp_q.push_back(3'd6);
    tick(2);
    pulse_ack();
    check("pre_rst_busy", 32'(cpu.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(cpu.busy), 0);
    check("arst_int1", 32'(cpu.int1), 0);
    check("arst_x",    32'(cpu.x), 0);
    check("arst_pend", 32'(pend_o), 0);
    p = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Parametrised, clocked interrupt controller: the registered successor of the 4-input combinational priority encoder. It accepts `N_SRC` peripheral request lines, latches them into a pending register, applies a per-source mask and fixed priority (highest index wins), and presents one interrupt at a time to the CPU through an ack / end-of-interrupt (eoi) handshake. It sits between the peripherals and the CPU interrupt input.

## Interface
- `N_SRC`, default 8: number of request sources; legal range 2..32.
- `ID_W`: localparam, `$clog2(N_SRC)`; width of the source id.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `p` input N_SRC: peripheral request lines; bit i is source i.
- `mask` input N_SRC: 1 = source enabled, 0 = source blocked from arbitration. Masking does not affect pending capture.
- `edge_mode` input N_SRC: 1 = edge-triggered source, 0 = level-sensitive source. Only used when `INTERRUPT_EDGE_EN` is defined.
- `ack` input 1: CPU accepts the presented interrupt; single-cycle pulse.
- `eoi` input 1: CPU has finished servicing; single-cycle pulse.
- `int1` output 1: interrupt presented to the CPU.
- `x` output ID_W: id of the presented or in-service source.
- `busy` output 1: an interrupt is in service.
- `pend_o` output N_SRC: pending register, for software visibility.

## Operation
- Reset: `pend`, `p_q`, `x`, `int1` and `busy` are all 0; the FSM is in IDLE.
- Capture, every cycle:
  - Level source: `pend[i] <= p[i]`.
  - Edge source: `pend[i]` sets on `p[i] & ~p_q[i]`, where `p_q` is `p` registered. It stays set until cleared by ack.
- Request vector: `req = pend & mask`.
- Priority: the highest set index of `req` wins. The winner's id is `win`.
- FSM:
  - IDLE: `int1=0`, `busy=0`. If `|req`, load `x <= win` and go to REQ.
  - REQ: `int1=1`, and `x` is frozen. A higher-priority arrival does not change `x`.
    - If `ack`: go to SERVICE. If source `x` is edge-mode, clear `pend[x]`.
    - Otherwise, if `req[x]==0` (level source dropped, or mask cleared): go to IDLE with `int1` low. This is spurious-request withdrawal.
  - SERVICE: `int1=0`, `busy=1`, `x` holds the active id. On `eoi`, go to IDLE.
  - Nesting is not supported. Requests arriving during SERVICE stay pending.
- A level source still asserted after `eoi` is re-requested.
- Boundary rules:
  - Set and clear of the same `pend` bit in one cycle: set wins, so no edge is lost.
  - `ack` outside REQ is ignored. `eoi` outside SERVICE is ignored.
  - `ack` and `eoi` together in REQ: `ack` is taken and `eoi` is ignored.
  - Repeated edges on one source while it is pending collapse into one interrupt.
  - Reset mid-handshake (any state) returns to IDLE immediately and asynchronously, clearing all pending bits.

## Timing
- `p` sampled high at edge t0 → `pend` set at t0 → REQ and `int1=1` after edge t1. Latency is 2 clock edges from request to `int1`.
- `ack` at edge t → `int1` low and `busy` high after t; the `pend` clear is visible after t.
- `eoi` at edge t → IDLE after t. The next `int1` can come after edge t+1 at the earliest.
- All outputs are registered (or decoded from state only); there is no combinational path from inputs to outputs.
- `x` is stable for the whole of REQ and SERVICE.

## Configuration
- `INTERRUPT_EDGE_EN` defined: per-source edge/level selection via `edge_mode`. The `p_q` register and edge detect logic are present.
- Not defined: every source is level-sensitive. `edge_mode` is ignored (port retained, unused), `p_q` is not built, and `ack` clears nothing.

## Test plan
- Reset and priority (N_SRC=8, all level, mask=8'hFF): `p=8'b1000_0001` → `int1=1` and `x=7` two edges later. `ack` → `busy=1`, `int1=0`. Drop `p[7]`, then `eoi` → `int1=1` and `x=0`.
- Masking: `p=8'h90`, `mask=8'h10` → `x=4`. While in REQ, set `mask=8'h00` → IDLE, `int1=0`, `pend_o=8'h90`.
- Edge mode (macro defined, `edge_mode=8'h04`): 1-cycle pulse on `p[2]` → `pend_o[2]` stays 1 until `ack`, and is 0 after `ack`. A second pulse during SERVICE → a new `int1` with `x=2` after `eoi`.
- Simultaneous set/clear (macro defined): rising edge on `p[2]` in the same cycle as `ack` for `x=2` → `pend_o[2]` remains 1.
- Handshake misuse: `ack` in IDLE and `eoi` in REQ → no state change. `ack` together with `eoi` in REQ → enters SERVICE.
- Async reset asserted mid-SERVICE between clock edges → `busy`, `int1`, `x` and `pend_o` all 0 immediately.
